// File: rtl/ins_fetcher_pkg.sv
// Shared widths, flags, FSM encoding and queue entry
// layout for the instruction fetch front end.
package ins_fetcher_pkg;

  localparam int Addr_SIZE = 32;
  localparam int Inst_SIZE = 32;
  localparam int Word_SIZE = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ASK  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [Inst_SIZE-1:0] inst;
    logic [Addr_SIZE-1:0] pc;
  } q_entry_t;

endpackage

// File: rtl/ins_fetcher_if_queue.sv
// In-order instruction queue holding {inst, pc} pairs;
// the head reads as zero while the queue is empty.
module if_queue
  import ins_fetcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  q_entry_t               din,
  output q_entry_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  q_entry_t      mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign count = cnt_q;
  assign head  = empty ? '0 : mem_q[rd_q];

  // a pop frees the slot a same-cycle push needs when full
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + {{PW{1'b0}}, do_push}
                    - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (en) begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en && do_push && !clear) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetcher: PC, one-outstanding fetch FSM
// towards mem_ctrl, and the decoder-facing queue.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  output logic        IF_MC_ask,
  output logic [31:0] IF_MC_Addr,
  input  logic        MC_IF_ok,
  input  logic        MC_IF_arrive,
  input  logic [31:0] MC_IF_Inst,
  output logic        IF_DEC_valid,
  output logic [31:0] IF_DEC_Inst,
  output logic [31:0] IF_DEC_PC,
  input  logic        DEC_IF_ready,
  input  logic        ROB_IF_flush,
  input  logic [31:0] ROB_IF_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  if_state_e state_q, state_d;

  logic [Addr_SIZE-1:0] pc_q, pc_d;
  logic [Addr_SIZE-1:0] req_pc_q, req_pc_d;
  logic [Addr_SIZE-1:0] addr_q, addr_d;
  logic                 ask_q, ask_d;

  q_entry_t      q_in;
  q_entry_t      q_head;
  logic          q_push;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic          q_space;

  assign q_space = !q_full && (q_count < CW'(QUEUE_DEPTH));
  assign q_in    = '{inst: MC_IF_Inst, pc: req_pc_q};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!ROB_IF_flush && q_space) state_d = ASK;
      ASK: begin
        if (MC_IF_ok)          state_d = ROB_IF_flush ? DROP : WAIT;
        else if (ROB_IF_flush) state_d = IDLE;
      end
      WAIT: begin
        if (MC_IF_arrive)      state_d = IDLE;
        else if (ROB_IF_flush) state_d = DROP;
      end
      // the stale word is owed regardless of a new redirect
      DROP: if (MC_IF_arrive) state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    ask_d    = ask_q;
    addr_d   = addr_q;
    q_push   = False;
    unique case (state_q)
      IDLE: begin
        if (!ROB_IF_flush && q_space) begin
          ask_d    = True;
          addr_d   = pc_q;
          req_pc_d = pc_q;
        end
      end
      ASK: if (MC_IF_ok) ask_d = False;
      WAIT: begin
        if (MC_IF_arrive && !ROB_IF_flush) begin
          q_push = True;
          pc_d   = req_pc_q + 32'd4;
        end
      end
      DROP: ;
    endcase
    if (ROB_IF_flush) begin
      pc_d  = ROB_IF_pc;
      ask_d = False;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      addr_q   <= '0;
      ask_q    <= False;
    end else if (rdy_in) begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      addr_q   <= addr_d;
      ask_q    <= ask_d;
    end
  end

  if_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk  (clk_in),
    .rst_n(rst_n_in),
    .en   (rdy_in),
    .push (q_push),
    .pop  (DEC_IF_ready),
    .clear(ROB_IF_flush),
    .din  (q_in),
    .head (q_head),
    .full (q_full),
    .empty(q_empty),
    .count(q_count)
  );

  assign IF_MC_ask    = ask_q;
  assign IF_MC_Addr   = addr_q;
  assign IF_DEC_valid = !q_empty;
  assign IF_DEC_Inst  = q_head.inst;
  assign IF_DEC_PC    = q_head.pc;

endmodule

// File: tb/tb_ins_fetcher.sv
// Bench for ins_fetcher: directed scenarios plus a
// randomized mem_ctrl/decoder/ROB run against a queue model.
module tb_ins_fetcher;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        ok = 1'b0;
  logic        arrive = 1'b0;
  logic        flush = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] mc_inst = '0;
  logic [31:0] rob_pc = '0;
  logic        ask;
  logic [31:0] addr;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ins_fetcher #(
    .QUEUE_DEPTH(DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .rdy_in      (rdy),
    .IF_MC_ask   (ask),
    .IF_MC_Addr  (addr),
    .MC_IF_ok    (ok),
    .MC_IF_arrive(arrive),
    .MC_IF_Inst  (mc_inst),
    .IF_DEC_valid(dec_valid),
    .IF_DEC_Inst (dec_inst),
    .IF_DEC_PC   (dec_pc),
    .DEC_IF_ready(pop),
    .ROB_IF_flush(flush),
    .ROB_IF_pc   (rob_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {ok, arrive, flush, pop} = '0;
    rdy = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_ask(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ask === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic serve(input logic [31:0] w, input int lat);
    ok = 1'b1;
    step();
    ok = 1'b0;
    repeat (lat) step();
    arrive = 1'b1;
    mc_inst = w;
    step();
    arrive = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vec++;
    if ({ask, addr} !== 33'h0) begin
      bad++;
      $display("FAIL reset_mc got %h want 0", {ask, addr});
    end
    vec++;
    if ({dec_valid, dec_inst, dec_pc} !== 65'h0) begin
      bad++;
      $display("FAIL reset_dec got %h want 0",
               {dec_valid, dec_inst, dec_pc});
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    step();
    vec++;
    if ({ask, addr} !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL first_ask got %h want %h", {ask, addr}, {1'b1, 32'h0});
    end
    serve(32'h00000013, 3);
    vec++;
    if ({dec_valid, dec_inst, dec_pc} !== {1'b1, 32'h13, 32'h0}) begin
      bad++;
      $display("FAIL first_head got %h want %h",
               {dec_valid, dec_inst, dec_pc}, {1'b1, 32'h13, 32'h0});
    end
    step();
    vec++;
    if ({ask, addr} !== {1'b1, 32'h4}) begin
      bad++;
      $display("FAIL second_ask got %h want %h", {ask, addr}, {1'b1, 32'h4});
    end
  endtask

  task automatic test_queue_full();
    logic [31:0] w [5];
    bit got;
    do_reset();
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      wait_ask(got);
      vec++;
      if (!got || addr !== 32'(i * 4)) begin
        bad++;
        $display("FAIL fill_ask got %0b/%h want 1/%h", got, addr, i * 4);
      end
      serve(w[i], $urandom_range(0, 3));
    end
    for (int i = 0; i < 6; i++) begin
      step();
      vec++;
      if (ask !== 1'b0) begin
        bad++;
        $display("FAIL full_no_ask got %b want 0", ask);
      end
    end
    vec++;
    if ({dec_valid, dec_inst, dec_pc} !== {1'b1, w[0], 32'h0}) begin
      bad++;
      $display("FAIL full_head got %h want %h",
               {dec_valid, dec_inst, dec_pc}, {1'b1, w[0], 32'h0});
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    wait_ask(got);
    vec++;
    if (!got || addr !== 32'd16) begin
      bad++;
      $display("FAIL refill_ask got %0b/%h want 1/10", got, addr);
    end
    serve(w[4], 1);
    pop = 1'b1;
    for (int i = 1; i < 5; i++) begin
      vec++;
      if ({dec_valid, dec_inst, dec_pc} !== {1'b1, w[i], 32'(i * 4)}) begin
        bad++;
        $display("FAIL drain_head got %h want %h",
                 {dec_valid, dec_inst, dec_pc}, {1'b1, w[i], 32'(i * 4)});
      end
      step();
    end
    pop = 1'b0;
    vec++;
    if (dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty got %b want 0", dec_valid);
    end
  endtask

  task automatic test_push_pop_wrap();
    logic [31:0] mi[$];
    logic [31:0] mp[$];
    logic [31:0] w;
    bit got;
    for (int i = 0; i < 3; i++) begin
      wait_ask(got);
      vec++;
      if (!got || addr !== 32'(20 + 4 * i)) begin
        bad++;
        $display("FAIL wrap_ask got %0b/%h want 1/%h", got, addr, 20 + 4 * i);
      end
      w = $urandom;
      serve(w, 1);
      mi.push_back(w);
      mp.push_back(addr);
    end
    wait_ask(got);
    vec++;
    if (!got || addr !== 32'd32) begin
      bad++;
      $display("FAIL wrap_ask4 got %0b/%h want 1/20", got, addr);
    end
    w = $urandom;
    ok = 1'b1;
    step();
    ok = 1'b0;
    step();
    arrive = 1'b1;
    mc_inst = w;
    pop = 1'b1;
    step();
    arrive = 1'b0;
    pop = 1'b0;
    void'(mi.pop_front());
    void'(mp.pop_front());
    mi.push_back(w);
    mp.push_back(32'd32);
    wait_ask(got);
    vec++;
    if (!got || addr !== 32'd36) begin
      bad++;
      $display("FAIL wrap_ask5 got %0b/%h want 1/24", got, addr);
    end
    w = $urandom;
    serve(w, 2);
    mi.push_back(w);
    mp.push_back(32'd36);
    repeat (3) step();
    vec++;
    if (ask !== 1'b0) begin
      bad++;
      $display("FAIL wrap_full_ask got %b want 0", ask);
    end
    pop = 1'b1;
    while (mi.size() != 0) begin
      vec++;
      if ({dec_valid, dec_inst, dec_pc} !== {1'b1, mi[0], mp[0]}) begin
        bad++;
        $display("FAIL wrap_order got %h want %h",
                 {dec_valid, dec_inst, dec_pc}, {1'b1, mi[0], mp[0]});
      end
      void'(mi.pop_front());
      void'(mp.pop_front());
      step();
    end
    pop = 1'b0;
  endtask

  task automatic test_flush_wait();
    bit got;
    do_reset();
    wait_ask(got);
    serve(32'h11, 1);
    wait_ask(got);
    vec++;
    if (!got || addr !== 32'h4) begin
      bad++;
      $display("FAIL fw_ask got %0b/%h want 1/4", got, addr);
    end
    ok = 1'b1;
    step();
    ok = 1'b0;
    flush = 1'b1;
    rob_pc = 32'h1000;
    step();
    flush = 1'b0;
    vec++;
    if ({dec_valid, ask} !== 2'b00) begin
      bad++;
      $display("FAIL fw_clear got %b want 00", {dec_valid, ask});
    end
    step();
    arrive = 1'b1;
    mc_inst = 32'hDEADBEEF;
    step();
    arrive = 1'b0;
    vec++;
    if (dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL fw_discard got %b want 0", dec_valid);
    end
    wait_ask(got);
    vec++;
    if (!got || addr !== 32'h1000 || dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL fw_redirect got %0b/%h/%b want 1/1000/0",
               got, addr, dec_valid);
    end
  endtask

  task automatic test_flush_ok();
    bit got;
    ok = 1'b1;
    flush = 1'b1;
    rob_pc = 32'h2000;
    step();
    ok = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (ask !== 1'b0) begin
        bad++;
        $display("FAIL fo_drop_ask got %b want 0", ask);
      end
      step();
    end
    arrive = 1'b1;
    mc_inst = $urandom;
    step();
    arrive = 1'b0;
    vec++;
    if (dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL fo_discard got %b want 0", dec_valid);
    end
    wait_ask(got);
    vec++;
    if (!got || addr !== 32'h2000) begin
      bad++;
      $display("FAIL fo_redirect got %0b/%h want 1/2000", got, addr);
    end
    ok = 1'b1;
    step();
    ok = 1'b0;
    step();
    arrive = 1'b1;
    flush = 1'b1;
    rob_pc = 32'h3000;
    mc_inst = $urandom;
    step();
    arrive = 1'b0;
    flush = 1'b0;
    vec++;
    if ({dec_valid, ask} !== 2'b00) begin
      bad++;
      $display("FAIL fa_discard got %b want 00", {dec_valid, ask});
    end
    step();
    vec++;
    if ({ask, addr} !== {1'b1, 32'h3000}) begin
      bad++;
      $display("FAIL fa_idle_ask got %h want %h", {ask, addr}, {1'b1, 32'h3000});
    end
  endtask

  task automatic test_rdy_hold();
    rdy = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++;
      if ({ask, addr} !== {1'b1, 32'h3000}) begin
        bad++;
        $display("FAIL rdy_hold got %h want %h", {ask, addr}, {1'b1, 32'h3000});
      end
    end
    rdy = 1'b1;
    ok = 1'b0;
    step();
    vec++;
    if (ask !== 1'b1) begin
      bad++;
      $display("FAIL rdy_still_ask got %b want 1", ask);
    end
    ok = 1'b1;
    step();
    ok = 1'b0;
    rdy = 1'b0;
    arrive = 1'b1;
    mc_inst = 32'hCAFE0001;
    step();
    rdy = 1'b1;
    vec++;
    if (dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL rdy_arrive_ignored got %b want 0", dec_valid);
    end
    step();
    arrive = 1'b0;
    vec++;
    if ({dec_valid, dec_inst, dec_pc} !== {1'b1, 32'hCAFE0001, 32'h3000}) begin
      bad++;
      $display("FAIL rdy_push got %h want %h",
               {dec_valid, dec_inst, dec_pc}, {1'b1, 32'hCAFE0001, 32'h3000});
    end
  endtask

  task automatic test_async_reset();
    bit got;
    wait_ask(got);
    vec++;
    if (!got || addr !== 32'h3004) begin
      bad++;
      $display("FAIL ar_ask got %0b/%h want 1/3004", got, addr);
    end
    ok = 1'b1;
    step();
    ok = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({ask, addr, dec_valid, dec_inst, dec_pc} !== 98'h0) begin
      bad++;
      $display("FAIL ar_outputs got %h want 0",
               {ask, addr, dec_valid, dec_inst, dec_pc});
    end
    step();
    rst_n = 1'b1;
    arrive = 1'b1;
    mc_inst = $urandom;
    step();
    arrive = 1'b0;
    vec++;
    if ({dec_valid, ask, addr} !== {2'b01, 32'h0}) begin
      bad++;
      $display("FAIL ar_late_arrive got %h want %h",
               {dec_valid, ask, addr}, {2'b01, 32'h0});
    end
  endtask

  task automatic test_random();
    logic [31:0] qi[$];
    logic [31:0] qp[$];
    logic [31:0] exp_pc, req, tgt, w;
    int phase, dly;
    bit stale, r, o, a, f, p;
    do_reset();
    exp_pc = 32'h0;
    req = 32'h0;
    phase = 0;
    dly = 0;
    stale = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      vec++;
      if (dec_valid !== (qi.size() != 0)) begin
        bad++;
        $display("FAIL rnd_valid c=%0d got %b want %b",
                 c, dec_valid, qi.size() != 0);
      end
      if (qi.size() != 0) begin
        vec++;
        if ({dec_inst, dec_pc} !== {qi[0], qp[0]}) begin
          bad++;
          $display("FAIL rnd_head c=%0d got %h want %h",
                   c, {dec_inst, dec_pc}, {qi[0], qp[0]});
        end
      end
      if (phase == 2) begin
        vec++;
        if (ask !== 1'b0) begin
          bad++;
          $display("FAIL rnd_ask_outstanding c=%0d got %b want 0", c, ask);
        end
      end
      if (phase == 0 && ask === 1'b1) begin
        vec++;
        if (addr !== exp_pc || qi.size() >= DEPTH) begin
          bad++;
          $display("FAIL rnd_addr c=%0d got %h/%0d want %h/<%0d",
                   c, addr, qi.size(), exp_pc, DEPTH);
        end
        req = addr;
        phase = 1;
        dly = $urandom_range(0, 2);
      end
      r = ($urandom_range(0, 7) != 0);
      o = (phase == 1 && dly == 0);
      a = (phase == 2 && dly == 0);
      f = ($urandom_range(0, 24) == 0);
      p = ($urandom_range(0, 2) == 0);
      w = $urandom;
      tgt = $urandom & 32'hFFFF_FFFC;
      rdy = r;
      ok = o;
      arrive = a;
      flush = f;
      pop = p;
      mc_inst = w;
      rob_pc = tgt;
      step();
      if (r) begin
        if (p && qi.size() != 0) begin
          void'(qi.pop_front());
          void'(qp.pop_front());
        end
        if (phase == 1) begin
          if (o) begin
            phase = 2;
            stale = f;
            dly = $urandom_range(0, 4);
          end else if (f) begin
            phase = 0;
          end else if (dly > 0) begin
            dly--;
          end
        end else if (phase == 2) begin
          if (a) begin
            phase = 0;
            if (!stale && !f) begin
              qi.push_back(w);
              qp.push_back(req);
              exp_pc = req + 32'd4;
            end
          end else begin
            if (f) stale = 1'b1;
            if (dly > 0) dly--;
          end
        end
        if (f) begin
          qi.delete();
          qp.delete();
          exp_pc = tgt;
        end
      end
    end
    rdy = 1'b1;
    {ok, arrive, flush, pop} = '0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_queue_full();
    test_push_pop_wrap();
    test_flush_wait();
    test_flush_ok();
    test_rdy_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
